// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte requesters.
// Latency: req_i sampled at an IDLE edge -> ack_o/tx_start_o high 1 cycle later; >= 4 cycles per byte.
// Backpressure: requesters hold req_i until ack_o; only one byte in flight, WAIT ends on tx_done_i or TIMEOUT.
//
// Ports:
//   uart_clk, reset_n       single clock, asynchronous active-low reset
//   req_i, req_data_i       per-requester request bit and byte (byte i at [i*DW +: DW])
//   ack_o, done_o           per-requester one-cycle accept / completion pulses
//   tx_start_o, tx_data_o   start pulse and byte presented to the transmitter
//   tx_done_i               transmitter completion pulse (honoured only while waiting)
//   grant_id_o              index of the current or last granted requester
//   busy_o, timeout_o       transfer in progress / aborted-transfer pulse
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic                      uart_clk,
    input  logic                      reset_n,
    input  logic [NREQ-1:0]           req_i,
    input  logic [NREQ*DW-1:0]        req_data_i,
    output logic [NREQ-1:0]           ack_o,
    output logic [NREQ-1:0]           done_o,
    output logic                      tx_start_o,
    output logic [DW-1:0]             tx_data_o,
    input  logic                      tx_done_i,
    output logic [$clog2(NREQ)-1:0]   grant_id_o,
    output logic                      busy_o,
    output logic                      timeout_o
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    logic [1:0]      r_state;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_grant;
    logic [CW-1:0]   r_cnt;
    logic [DW-1:0]   r_tx_data;
    logic [NREQ-1:0] r_ack;
    logic [NREQ-1:0] r_done;
    logic            r_tx_start;
    logic            r_busy;
    logic            r_timeout;

    logic            w_found;
    logic [IW-1:0]   w_gnt;
    logic [IW-1:0]   w_ptr_nxt;
    int              w_idx;

    // Rotating priority search starting at r_ptr. The loop runs from the
    // farthest offset down to offset 0 so the nearest set bit is written last.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = r_ptr;
        w_idx   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (req_i[w_idx]) begin
                w_found = 1'b1;
                w_gnt   = IW'(w_idx);
            end
        end
    end

    // Pointer moves one past the winner so the winner has lowest priority next time.
    assign w_ptr_nxt = (w_gnt == IW'(NREQ - 1)) ? '0 : (w_gnt + 1'b1);

    always_ff @(posedge uart_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_grant    <= '0;
            r_cnt      <= '0;
            r_tx_data  <= '0;
            r_ack      <= '0;
            r_done     <= '0;
            r_tx_start <= 1'b0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            // Pulse outputs default low; each is raised for exactly one state.
            r_ack      <= '0;
            r_done     <= '0;
            r_tx_start <= 1'b0;
            r_timeout  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state    <= S_START;
                        r_grant    <= w_gnt;
                        r_ptr      <= w_ptr_nxt;
                        r_tx_data  <= req_data_i[w_gnt*DW +: DW];
                        r_ack      <= ONE_HOT0 << w_gnt;
                        r_tx_start <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_START: begin
                    r_state <= S_WAIT;
                    r_cnt   <= '0;
                end
                S_WAIT: begin
                    // Completion is checked first so it wins over a same-cycle timeout.
                    // r_cnt holds (WAIT cycles elapsed - 1) during each WAIT cycle.
                    if (tx_done_i) begin
                        r_state <= S_DONE;
                        r_done  <= ONE_HOT0 << r_grant;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_state   <= S_DONE;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ack_o      = r_ack;
    assign done_o     = r_done;
    assign tx_start_o = r_tx_start;
    assign tx_data_o  = r_tx_data;
    assign grant_id_o = r_grant;
    assign busy_o     = r_busy;
    assign timeout_o  = r_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios with literal expectations plus a
// transaction-level model compared against every output on every falling edge.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_uart_tx_arbiter;

    localparam int NREQ    = 4;
    localparam int DW      = 8;
    localparam int TIMEOUT = 16;

    logic                 uart_clk   = 1'b0;
    logic                 reset_n    = 1'b1;
    logic [NREQ-1:0]      req_i      = '0;
    logic [NREQ*DW-1:0]   req_data_i = {8'h3C, 8'hA5, 8'h5A, 8'h11};
    logic                 tx_done_i  = 1'b0;
    logic [NREQ-1:0]      ack_o;
    logic [NREQ-1:0]      done_o;
    logic                 tx_start_o;
    logic [DW-1:0]        tx_data_o;
    logic [1:0]           grant_id_o;
    logic                 busy_o;
    logic                 timeout_o;

    int checks   = 0;
    int failures = 0;
    int n_ack1   = 0;

    uart_tx_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .uart_clk   (uart_clk),
        .reset_n    (reset_n),
        .req_i      (req_i),
        .req_data_i (req_data_i),
        .ack_o      (ack_o),
        .done_o     (done_o),
        .tx_start_o (tx_start_o),
        .tx_data_o  (tx_data_o),
        .tx_done_i  (tx_done_i),
        .grant_id_o (grant_id_o),
        .busy_o     (busy_o),
        .timeout_o  (timeout_o)
    );

    always #5 uart_clk = ~uart_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // A transfer is described by its age in cycles since the grant (1 = start
    // cycle, 2.. = waiting cycles) and how it ended (0 none, 1 done, 2 timeout).
    int               m_active = 0;
    int               m_age    = 0;
    int               m_g      = 0;
    int               m_ptr    = 0;
    int               m_end    = 0;
    logic [DW-1:0]    m_data   = '0;

    always @(posedge uart_clk or negedge reset_n) begin
        if (!reset_n) begin
            m_active = 0; m_age = 0; m_g = 0; m_ptr = 0; m_end = 0; m_data = '0;
        end else if (m_active == 0) begin
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (m_ptr + k) % NREQ;
                if (m_active == 0 && req_i[idx]) begin
                    m_active = 1;
                    m_age    = 1;
                    m_g      = idx;
                    m_data   = req_data_i[idx*DW +: DW];
                    m_ptr    = (idx + 1) % NREQ;
                    m_end    = 0;
                end
            end
        end else if (m_end != 0) begin
            m_active = 0;
            m_end    = 0;
        end else begin
            if (m_age >= 2) begin
                if (tx_done_i)
                    m_end = 1;
                else if (m_age - 1 == TIMEOUT)
                    m_end = 2;
            end
            m_age++;
        end
    end

    logic [NREQ-1:0] e_ack, e_done, one_hot;
    logic            e_start;

    always @(negedge uart_clk) begin
        one_hot = NREQ'(1) << m_g;
        e_start = (m_active != 0) && (m_age == 1) && (m_end == 0);
        e_ack   = e_start ? one_hot : '0;
        e_done  = (m_end == 1) ? one_hot : '0;
        chk("cyc ack_o",      ack_o,      e_ack);
        chk("cyc tx_start_o", tx_start_o, e_start);
        chk("cyc done_o",     done_o,     e_done);
        chk("cyc timeout_o",  timeout_o,  m_end == 2);
        chk("cyc busy_o",     busy_o,     m_active != 0);
        chk("cyc tx_data_o",  tx_data_o,  m_data);
        chk("cyc grant_id_o", grant_id_o, m_g);
        if (ack_o[1] === 1'b1) n_ack1++;
    end

    // ---------------- stimulus helpers ----------------
    // One clock: tx_done_i is a single-cycle pulse, and every requester
    // drops its request in the cycle it sees its ack.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge uart_clk);
            #1;
            tx_done_i = 1'b0;
            req_i     = req_i & ~ack_o;
        end
    endtask

    task automatic wait_start(input string name, input int exp_g);
        int n = 0;
        int g = -1;
        while (tx_start_o !== 1'b1 && n < 50) begin
            tick(1);
            n++;
        end
        for (int i = 0; i < NREQ; i++)
            if (tx_start_o === 1'b1 && ack_o[i] === 1'b1) g = i;
        chk(name, g, exp_g);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy_o !== 1'b0 && n < 50) begin
            tick(1);
            n++;
        end
        chk(name, busy_o, 1'b0);
    endtask

    task automatic serve(input string name, input int exp_g);
        wait_start(name, exp_g);
        tick(2);
        tx_done_i = 1'b1;
        tick(1);
        wait_idle({name, " idle"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1;
        #1 reset_n = 1'b0;
        tick(2);
        chk("reset busy_o",     busy_o,     1'b0);
        chk("reset tx_data_o",  tx_data_o,  8'h00);
        chk("reset grant_id_o", grant_id_o, 2'd0);

        // Single request from requester 2 granted on the first edge after release.
        reset_n = 1'b1;
        req_i   = 4'b0100;
        tick(1);
        chk("single ack_o",      ack_o,      4'b0100);
        chk("single tx_start_o", tx_start_o, 1'b1);
        chk("single tx_data_o",  tx_data_o,  8'hA5);
        chk("single grant_id_o", grant_id_o, 2'd2);
        tick(4);
        tx_done_i = 1'b1;
        tick(1);
        chk("single done_o",    done_o,    4'b0100);
        chk("single timeout_o", timeout_o, 1'b0);
        tick(1);
        chk("single done_o once", done_o,   4'b0000);
        chk("single busy_o low",  busy_o,   1'b0);
        chk("single data held",   tx_data_o, 8'hA5);

        // Round robin from a freshly reset pointer.
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        req_i   = 4'b1111;
        serve("rr g0", 0);
        serve("rr g1", 1);
        serve("rr g2", 2);
        serve("rr g3", 3);
        req_i = 4'b1001;
        serve("rr2 g0", 0);
        serve("rr2 g3", 3);

        // No completion: abort after TIMEOUT waiting cycles.
        req_i = 4'b0001;
        wait_start("to grant", 0);
        tick(TIMEOUT + 1);
        chk("to timeout_o", timeout_o, 1'b1);
        chk("to done_o",    done_o,    4'b0000);
        tick(1);
        chk("to busy_o low",    busy_o,    1'b0);
        chk("to timeout once",  timeout_o, 1'b0);

        // Completion in start cycle ignored; completion on last waiting cycle wins.
        req_i = 4'b0010;
        wait_start("late grant", 1);
        tx_done_i = 1'b1;
        tick(1);
        chk("late start pulse ignored", done_o, 4'b0000);
        tick(TIMEOUT - 1);
        tx_done_i = 1'b1;
        tick(1);
        chk("late done_o",    done_o,    4'b0010);
        chk("late timeout_o", timeout_o, 1'b0);
        wait_idle("late idle");

        // Reset in the middle of a wait for requester 3.
        req_i = 4'b1000;
        wait_start("abort grant", 3);
        tick(3);
        #2 reset_n = 1'b0;
        #1;
        chk("abort busy_o",     busy_o,     1'b0);
        chk("abort tx_data_o",  tx_data_o,  8'h00);
        chk("abort grant_id_o", grant_id_o, 2'd0);
        chk("abort ack_o",      ack_o,      4'b0000);
        req_i = 4'b1001;
        tick(2);
        reset_n = 1'b1;
        serve("post g0", 0);
        serve("post g3", 3);

        // A request withdrawn before any grant is never acknowledged.
        req_i = 4'b0001;
        wait_start("wd grant", 0);
        tick(1);
        a1 = n_ack1;
        req_i[1] = 1'b1;
        tick(1);
        req_i[1] = 1'b0;
        tick(1);
        tx_done_i = 1'b1;
        tick(1);
        wait_idle("wd idle");
        tick(4);
        chk("wd req1 acks", n_ack1 - a1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
